fft_input_loader: RTL and testbench
===================================

Name: fft_input_loader

Overview:
Write-side counterpart of the FFT read/output address controller. It takes bytes from the UART receiver and assembles them into samples. Each sample is written into the FFT working memory at its bit-reversed address. After N samples it pulses flag_start_FFT, then holds off further input until the output side reports done.

Parameters:
N, 16, FFT length (samples per frame)
SIZE, 4, log2(N); write-address width
DATA_W, 16, sample width written to memory (must be <= 8*SAMPLE_BYTES)
SAMPLE_BYTES, 2, UART bytes per sample, little-endian
t_1_bit, 5207, clk cycles per UART bit
TIMEOUT_BITS, 20, inter-byte gap, in bit times, that aborts a partial sample

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle strobe per received byte
rx_byte  in  8  received byte, valid with rx_valid
fft_done  in  1  one-cycle pulse from output generator (done_o); frees memory
wr_en  out  1  memory write strobe
wr_ptr  out  SIZE  memory write address
wr_data  out  DATA_W  memory write data
flag_start_FFT  out  1  one-cycle pulse, frame loaded
busy  out  1  high while FFT/output owns memory (input ignored)
frame_err  out  1  one-cycle pulse on inter-byte timeout

Behaviour:
- Reset (async, any time, including mid-frame): all outputs 0; byte_cnt, sample_cnt and timer cleared; state COLLECT.
- States:
  - COLLECT: accept bytes.
  - START: 1 cycle, flag_start_FFT=1.
  - WAIT_DONE: busy=1.
- Transitions:
  - COLLECT -> START on the write of sample N-1.
  - START -> WAIT_DONE unconditionally.
  - WAIT_DONE -> COLLECT on fft_done; counters already zero.
- Byte assembly (COLLECT, rx_valid=1): byte shifted in at position byte_cnt, so the first byte is the LSB; byte_cnt increments.
- Final byte (byte_cnt==SAMPLE_BYTES-1): byte_cnt->0. Next cycle: wr_en=1, wr_data = assembled word[DATA_W-1:0], wr_ptr = bitrev(sample_cnt); sample_cnt increments modulo N.
- Latency: wr_en 1 cycle after the final rx_valid; flag_start_FFT 1 cycle after the last wr_en.
- Outputs are registered; wr_en and flag_start_FFT are single-cycle pulses.
- rx_valid in START or WAIT_DONE: byte dropped, no state change.
- fft_done outside WAIT_DONE: ignored.
- Simultaneous rx_valid and fft_done in WAIT_DONE: transition taken, byte dropped.
- Timeout:
  - Timer runs only in COLLECT while byte_cnt!=0.
  - Timer clears on every rx_valid.
  - Reaching TIMEOUT_BITS*t_1_bit-1: partial sample discarded (byte_cnt=0), frame_err pulses, sample_cnt unchanged.
  - rx_valid in the same cycle as expiry: byte accepted, no error.
- Timer width: $clog2(TIMEOUT_BITS*t_1_bit).
- Sample counter wrap: at N-1 it wraps to 0 at the same time as entry to START.

Optional Feature:
BIT_REVERSE_EN
- Defined: wr_ptr = bit-reversed sample_cnt (memory in decimation-in-time input order).
- Undefined: wr_ptr = sample_cnt (natural order). Used when the FFT core reorders internally.
- All other timing is identical in both builds.

Decomposition:
- Shared package fft_pkg:
  - state encoding constants (COLLECT, START, WAIT_DONE);
  - bitrev function parameterised by SIZE;
  - constant TIMEOUT_CYC = TIMEOUT_BITS*t_1_bit.
- One sub-module, byte_timeout_timer: inputs clk, rst, run, clear; output expire. Timer counter isolated so it can be reused by the output side.

Test Plan:
- Full frame, BIT_REVERSE_EN: 16 samples, bytes {k, 0xA0} for k=0..15 -> sample 1 written as wr_data=0xA001 at wr_ptr=8; sample 3 as 0xA003 at 12; flag_start_FFT exactly 1 cycle after the 16th wr_en; busy=1 afterwards.
- Hold-off: in WAIT_DONE send 5 bytes -> no wr_en. Then pulse fft_done and send {0x55,0x66} -> wr_en with 0x6655 at wr_ptr=0.
- Timeout: send one byte, idle 20*5207 cycles -> frame_err pulse, no wr_en. Then {0x01,0x02} -> 0x0201 written at the next sample index (unchanged).
- Expiry race: second byte arrives on the expiry cycle -> sample written, frame_err stays 0.
- Reset mid-frame: assert rst after 7 samples -> outputs 0 immediately (async). After release the next sample goes to wr_ptr=0 and 16 more samples are needed for flag_start_FFT.
- BIT_REVERSE_EN undefined: same frame as the first scenario -> sample k written at wr_ptr=k.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT input/output address controllers:
//   - state_e     : loader FSM state encoding (COLLECT, START, WAIT_DONE)
//   - bitrev()    : reverses the low 'size' bits of a value (DIT input order)
//   - TIMEOUT_CYC : default inter-byte timeout in clock cycles
// -----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam int DEF_T_1_BIT      = 5207;
    localparam int DEF_TIMEOUT_BITS = 20;
    localparam int TIMEOUT_CYC      = DEF_TIMEOUT_BITS * DEF_T_1_BIT;

    // Reverse the low 'size' bits of v; bits above 'size' are returned as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int size);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < size; i++) begin
            r[i] = v[size-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// -----------------------------------------------------------------------------
// byte_timeout_timer
// Inter-byte gap timer. Counts clock cycles while 'run' is high and 'clear'
// is low; raises 'expire' during the cycle in which the count reaches CYC-1.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous, active-high reset
//   run    in  count enable; when low the counter is held at zero
//   clear  in  synchronous clear (a byte arrived)
//   expire out combinational, high while running with count == CYC-1
// -----------------------------------------------------------------------------
module byte_timeout_timer
    import fft_pkg::*;
#(
    parameter int CYC = TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

    logic [W-1:0] count_q, count_d;

    // NOTE: every branch assigns count_d, so no latch is inferred.
    always_comb begin
        if (clear || !run) begin
            count_d = '0;
        end else begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = run && (count_q == W'(CYC - 1));

endmodule

// File: rtl/fft_input_loader.sv
// -----------------------------------------------------------------------------
// fft_input_loader
// Assembles little-endian UART bytes into samples and writes each sample into
// the FFT working memory. After N samples it pulses flag_start_FFT and ignores
// input until fft_done hands the memory back. A partial sample is dropped
// (frame_err pulse) if the gap between bytes reaches TIMEOUT_BITS bit times.
//
// Build option: define BIT_REVERSE_EN to write samples at bit-reversed
// addresses; otherwise samples are written in natural order.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   rx_valid       in   one-cycle strobe per received byte
//   rx_byte        in   received byte
//   fft_done       in   output side finished; memory free again
//   wr_en          out  memory write strobe (one cycle)
//   wr_ptr         out  memory write address
//   wr_data        out  memory write data
//   flag_start_FFT out  one-cycle pulse, frame loaded
//   busy           out  high while the FFT/output side owns the memory
//   frame_err      out  one-cycle pulse on inter-byte timeout
// -----------------------------------------------------------------------------
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N            = 16,
    parameter int SIZE         = 4,
    parameter int DATA_W       = 16,
    parameter int SAMPLE_BYTES = 2,
    parameter int t_1_bit      = DEF_T_1_BIT,
    parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              fft_done,
    output logic              wr_en,
    output logic [SIZE-1:0]   wr_ptr,
    output logic [DATA_W-1:0] wr_data,
    output logic              flag_start_FFT,
    output logic              busy,
    output logic              frame_err
);

    localparam int WORD_W = 8 * SAMPLE_BYTES;
    localparam int BC_W   = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;

    state_e              state_q, state_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [SIZE-1:0]     sample_cnt_q, sample_cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                wr_en_q, wr_en_d;
    logic [SIZE-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                flag_q, flag_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                last_byte;
    logic                last_sample;
    logic                timer_run;
    logic                timer_expire;
    logic [SIZE-1:0]     ptr_map;

    assign last_byte   = (byte_cnt_q == BC_W'(SAMPLE_BYTES - 1));
    assign last_sample = (sample_cnt_q == SIZE'(N - 1));
    assign timer_run   = (state_q == COLLECT) && (byte_cnt_q != '0);

`ifdef BIT_REVERSE_EN
    assign ptr_map = SIZE'(bitrev(32'(sample_cnt_q), SIZE));
`else
    assign ptr_map = sample_cnt_q;
`endif

    byte_timeout_timer #(
        .CYC (TIMEOUT_BITS * t_1_bit)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .clear  (rx_valid),
        .expire (timer_expire)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT:   if (rx_valid && last_byte && last_sample) state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (fft_done) state_d = COLLECT;
            default:   state_d = COLLECT;
        endcase
    end

    // ---------------- FSM: outputs (registered below) ----------------
    // busy follows the next state so it is high exactly while state_q is
    // WAIT_DONE, rising together with the flag_start_FFT pulse.
    always_comb begin
        flag_d = (state_q == START);
        busy_d = (state_d == WAIT_DONE);
    end

    // ---------------- Byte assembly and memory write ----------------
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        sample_cnt_d = sample_cnt_q;
        word_d       = word_q;
        wr_en_d      = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        wr_data_d    = wr_data_q;
        err_d        = 1'b0;
        if (state_q == COLLECT) begin
            if (rx_valid) begin
                // A byte on the expiry cycle wins over the timeout.
                word_d[int'(byte_cnt_q)*8 +: 8] = rx_byte;
                if (last_byte) begin
                    byte_cnt_d   = '0;
                    wr_en_d      = 1'b1;
                    wr_data_d    = word_d[DATA_W-1:0];
                    wr_ptr_d     = ptr_map;
                    sample_cnt_d = last_sample ? '0 : sample_cnt_q + SIZE'(1);
                end else begin
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                end
            end else if (timer_expire) begin
                byte_cnt_d = '0;
                err_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q   <= '0;
            sample_cnt_q <= '0;
            word_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_ptr_q     <= '0;
            wr_data_q    <= '0;
            flag_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            word_q       <= word_d;
            wr_en_q      <= wr_en_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_data_q    <= wr_data_d;
            flag_q       <= flag_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_ptr         = wr_ptr_q;
    assign wr_data        = wr_data_q;
    assign flag_start_FFT = flag_q;
    assign busy           = busy_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// -----------------------------------------------------------------------------
// tb_fft_input_loader
// Directed scoreboard bench for fft_input_loader. Stimulus pushes expected
// events (write, start, error) into a queue; a negedge monitor pops and
// compares whenever the DUT raises wr_en, flag_start_FFT or frame_err.
// The bit time is shortened so the 20-bit-time timeout is 100 cycles.
// Define BIT_REVERSE_EN for both the bench and the RTL to test that build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_input_loader;

    localparam int N      = 16;
    localparam int SIZE   = 4;
    localparam int DATA_W = 16;
    localparam int SB     = 2;
    localparam int T1B    = 5;
    localparam int TOB    = 20;
    localparam int CYC    = T1B * TOB;

    localparam int EV_WR    = 0;
    localparam int EV_START = 1;
    localparam int EV_ERR   = 2;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte  = 8'h00;
    logic              fft_done = 1'b0;
    logic              wr_en;
    logic [SIZE-1:0]   wr_ptr;
    logic [DATA_W-1:0] wr_data;
    logic              flag_start_FFT;
    logic              busy;
    logic              frame_err;

    fft_input_loader #(
        .N            (N),
        .SIZE         (SIZE),
        .DATA_W       (DATA_W),
        .SAMPLE_BYTES (SB),
        .t_1_bit      (T1B),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .fft_done       (fft_done),
        .wr_en          (wr_en),
        .wr_ptr         (wr_ptr),
        .wr_data        (wr_data),
        .flag_start_FFT (flag_start_FFT),
        .busy           (busy),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                kind;
        logic [SIZE-1:0]   ptr;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec       = 0;
    int  n_err       = 0;
    int  cyc         = 0;
    int  last_wr_cyc = -10;
    int  sidx        = 0;
    ev_t mon_e;
    int  mon_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected write address for sample index k.
    function automatic logic [SIZE-1:0] exp_ptr(input int k);
        logic [SIZE-1:0] v;
        v = SIZE'(k);
`ifdef BIT_REVERSE_EN
        return {v[0], v[1], v[2], v[3]};
`else
        return v;
`endif
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst && (wr_en || flag_start_FFT || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'({wr_en, flag_start_FFT, frame_err}), 32'd0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_got = wr_en ? EV_WR : (flag_start_FFT ? EV_START : EV_ERR);
                check("event_kind", 32'(mon_got), 32'(mon_e.kind));
                if (mon_e.kind == EV_WR) begin
                    check("wr_ptr", 32'(wr_ptr), 32'(mon_e.ptr));
                    check("wr_data", 32'(wr_data), 32'(mon_e.data));
                    last_wr_cyc = cyc;
                end else if (mon_e.kind == EV_START) begin
                    check("start_latency", 32'(cyc - last_wr_cyc), 32'd1);
                    check("busy_at_start", 32'(busy), 32'd1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_wr(input logic [7:0] lo, input logic [7:0] hi);
        ev_t e;
        e.kind = EV_WR;
        e.ptr  = exp_ptr(sidx);
        e.data = {hi, lo};
        exp_q.push_back(e);
        if (sidx == N - 1) begin
            e.kind = EV_START;
            exp_q.push_back(e);
            sidx = 0;
        end else begin
            sidx++;
        end
    endtask

    task automatic push_err();
        ev_t e;
        e.kind = EV_ERR;
        e.ptr  = '0;
        e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [7:0] lo, input logic [7:0] hi);
        push_wr(lo, hi);
        send_byte(lo);
        send_byte(hi);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},     32'(wr_en), 32'd0);
        check({tag, "_wr_ptr"},    32'(wr_ptr), 32'd0);
        check({tag, "_wr_data"},   32'(wr_data), 32'd0);
        check({tag, "_flag"},      32'(flag_start_FFT), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d expected events pending", exp_q.size());
        $fatal(1, "time limit");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset state.
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Full frame {k, 0xA0}; a stray fft_done mid-sample is ignored.
        for (int k = 0; k < N; k++) begin
            if (k == 5) begin
                push_wr(8'(k), 8'hA0);
                send_byte(8'(k));
                fft_done = 1'b1;
                step();
                fft_done = 1'b0;
                send_byte(8'hA0);
            end else begin
                send_sample(8'(k), 8'hA0);
            end
        end
        drain();
        idle(2);
        check("busy_after_frame", 32'(busy), 32'd1);

        // Hold-off: bytes in WAIT_DONE are dropped.
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        idle(3);
        check("busy_holdoff", 32'(busy), 32'd1);
        // fft_done together with a byte: transition taken, byte dropped.
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        fft_done = 1'b1;
        step();
        rx_valid = 1'b0;
        fft_done = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        send_sample(8'h55, 8'h66);
        drain();

        // Timeout: one byte then a full gap discards the partial sample.
        push_err();
        send_byte(8'h99);
        idle(CYC - 1);
        check("frame_err_early", 32'(frame_err), 32'd0);
        step();
        check("frame_err_pulse", 32'(frame_err), 32'd1);
        step();
        check("frame_err_single", 32'(frame_err), 32'd0);
        send_sample(8'h01, 8'h02);
        drain();

        // Expiry race: second byte lands on the expiry cycle and is kept.
        push_wr(8'h11, 8'h22);
        send_byte(8'h11);
        idle(CYC - 1);
        send_byte(8'h22);
        idle(CYC + 5);
        drain();

        // Reset mid-frame: samples 3..6 written, then a partial byte.
        for (int k = 3; k < 7; k++) send_sample(8'(k), 8'hC0);
        drain();
        send_byte(8'hEE);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        idle(2);
        rst  = 1'b0;
        sidx = 0;

        // A full new frame is needed, starting at address 0.
        for (int k = 0; k < N; k++) send_sample(8'(k), 8'hB0);
        drain();
        idle(2);
        check("busy_after_frame2", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
